// File: rtl/fu_issue_arbiter_if.sv
// Issue-stage handshake between the reservation station and the FU issue arbiter.
// The RS side drives requests; the arbiter returns per-class grants and busy status.
interface fu_issue_arbiter_if #(
    parameter int RS_SIZE = 16,
    parameter int NUM_ALU = 2
);
    localparam int IDX_W = $clog2(RS_SIZE);

    logic [RS_SIZE-1:0]       req_valid;
    logic [2*RS_SIZE-1:0]     req_fu;
    logic                     squash;
    logic                     mem_done;

    logic [NUM_ALU-1:0]       alu_grant_valid;
    logic [NUM_ALU*IDX_W-1:0] alu_grant_idx;
    logic                     mul_grant_valid;
    logic [IDX_W-1:0]         mul_grant_idx;
    logic                     mem_grant_valid;
    logic [IDX_W-1:0]         mem_grant_idx;
    logic [RS_SIZE-1:0]       grant_vec;
    logic                     mul_busy;
    logic                     mem_busy;

    modport master (
        output req_valid, req_fu, squash, mem_done,
        input  alu_grant_valid, alu_grant_idx, mul_grant_valid, mul_grant_idx,
               mem_grant_valid, mem_grant_idx, grant_vec, mul_busy, mem_busy
    );

    modport slave (
        input  req_valid, req_fu, squash, mem_done,
        output alu_grant_valid, alu_grant_idx, mul_grant_valid, mul_grant_idx,
               mem_grant_valid, mem_grant_idx, grant_vec, mul_busy, mem_busy
    );
endinterface

// File: rtl/fu_issue_arbiter.sv
// Issue-stage scheduler: round-robin grants of ready RS entries to the ALUs, the
// unpipelined multiplier and the single memory port, with MUL/MEM occupancy tracking.
module fu_issue_arbiter #(
    parameter int RS_SIZE = 16,
    parameter int NUM_ALU = 2,
    parameter int MUL_LAT = 4
) (
    input logic               clock,
    input logic               reset,
    fu_issue_arbiter_if.slave bus
);
    localparam int IDX_W = $clog2(RS_SIZE);
    localparam int CNT_W = $clog2(MUL_LAT + 1);

    localparam logic [1:0] FUNC_ALU = 2'd0;
    localparam logic [1:0] FUNC_MUL = 2'd1;
    localparam logic [1:0] FUNC_MEM = 2'd2;

    localparam logic [CNT_W-1:0] MUL_RELOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic [IDX_W-1:0] alu_ptr;
    logic [IDX_W-1:0] mul_ptr;
    logic [IDX_W-1:0] mem_ptr;
    logic [CNT_W-1:0] mul_cnt;
    logic             mem_out;

    logic [RS_SIZE-1:0] elig_alu;
    logic [RS_SIZE-1:0] elig_mul;
    logic [RS_SIZE-1:0] elig_mem;
    logic               issue_ok;
    logic               mul_free;
    logic               mem_free;

    logic [NUM_ALU-1:0] alu_v;
    logic [IDX_W-1:0]   alu_i [NUM_ALU];
    logic [IDX_W-1:0]   alu_last;
    logic               mul_v;
    logic [IDX_W-1:0]   mul_i;
    logic               mem_v;
    logic [IDX_W-1:0]   mem_i;
    logic [RS_SIZE-1:0] gvec;

    // Modular add that also handles non-power-of-2 RS_SIZE; off never exceeds RS_SIZE.
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= RS_SIZE) sum = sum - RS_SIZE;
        return IDX_W'(sum);
    endfunction

    always_comb begin
        elig_alu = '0;
        elig_mul = '0;
        elig_mem = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            elig_alu[i] = bus.req_valid[i] && (bus.req_fu[2*i +: 2] == FUNC_ALU);
            elig_mul[i] = bus.req_valid[i] && (bus.req_fu[2*i +: 2] == FUNC_MUL);
            elig_mem[i] = bus.req_valid[i] && (bus.req_fu[2*i +: 2] == FUNC_MEM);
        end
    end

    assign issue_ok = !reset && !bus.squash;
    assign mul_free = (mul_cnt == '0);
    assign mem_free = !mem_out || bus.mem_done;

    always_comb begin
        int               filled;
        logic [IDX_W-1:0] idx;
        alu_v    = '0;
        alu_last = '0;
        filled   = 0;
        idx      = '0;
        for (int s = 0; s < NUM_ALU; s++) alu_i[s] = '0;
        for (int k = 0; k < RS_SIZE; k++) begin
            idx = wrap_add(alu_ptr, k);
            if (issue_ok && elig_alu[idx] && (filled < NUM_ALU)) begin
                for (int s = 0; s < NUM_ALU; s++) begin
                    if (s == filled) begin
                        alu_v[s] = 1'b1;
                        alu_i[s] = idx;
                    end
                end
                filled   = filled + 1;
                alu_last = idx;
            end
        end
    end

    always_comb begin
        logic             found;
        logic [IDX_W-1:0] idx;
        found = 1'b0;
        mul_i = '0;
        idx   = '0;
        for (int k = 0; k < RS_SIZE; k++) begin
            idx = wrap_add(mul_ptr, k);
            if (!found && issue_ok && mul_free && elig_mul[idx]) begin
                found = 1'b1;
                mul_i = idx;
            end
        end
        mul_v = found;
    end

    always_comb begin
        logic             found;
        logic [IDX_W-1:0] idx;
        found = 1'b0;
        mem_i = '0;
        idx   = '0;
        for (int k = 0; k < RS_SIZE; k++) begin
            idx = wrap_add(mem_ptr, k);
            if (!found && issue_ok && mem_free && elig_mem[idx]) begin
                found = 1'b1;
                mem_i = idx;
            end
        end
        mem_v = found;
    end

    always_comb begin
        gvec = '0;
        for (int s = 0; s < NUM_ALU; s++) begin
            if (alu_v[s]) gvec[alu_i[s]] = 1'b1;
        end
        if (mul_v) gvec[mul_i] = 1'b1;
        if (mem_v) gvec[mem_i] = 1'b1;
    end

    for (genvar s = 0; s < NUM_ALU; s++) begin : g_alu_out
        assign bus.alu_grant_idx[s*IDX_W +: IDX_W] = alu_i[s];
    end

    assign bus.alu_grant_valid = alu_v;
    assign bus.mul_grant_valid = mul_v;
    assign bus.mul_grant_idx   = mul_i;
    assign bus.mem_grant_valid = mem_v;
    assign bus.mem_grant_idx   = mem_i;
    assign bus.grant_vec       = gvec;
    // Busy flags come straight from registered state, which reset clears asynchronously.
    assign bus.mul_busy        = !mul_free;
    assign bus.mem_busy        = mem_out;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            alu_ptr <= '0;
            mul_ptr <= '0;
            mem_ptr <= '0;
            mul_cnt <= '0;
            mem_out <= 1'b0;
        end else if (bus.squash) begin
            alu_ptr <= '0;
            mul_ptr <= '0;
            mem_ptr <= '0;
            mul_cnt <= '0;
            mem_out <= 1'b0;
        end else begin
            if (alu_v != '0) alu_ptr <= wrap_add(alu_last, 1);

            if (mul_v) begin
                mul_cnt <= MUL_RELOAD;
                mul_ptr <= wrap_add(mul_i, 1);
            end else if (!mul_free) begin
                mul_cnt <= mul_cnt - CNT_ONE;
            end

            // A new grant in the same cycle as mem_done keeps the port outstanding.
            if (mem_v) begin
                mem_out <= 1'b1;
                mem_ptr <= wrap_add(mem_i, 1);
            end else if (bus.mem_done) begin
                mem_out <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fu_issue_arbiter.sv
// Scenario bench for fu_issue_arbiter: expected grant snapshots are queued as stimulus
// is applied and compared against the DUT once the combinational outputs settle.
module tb_fu_issue_arbiter;
    localparam logic [1:0] F_ALU = 2'd0;
    localparam logic [1:0] F_MUL = 2'd1;
    localparam logic [1:0] F_MEM = 2'd2;
    localparam logic [1:0] F_BAD = 2'd3;

    typedef struct packed {
        logic [1:0]  alu_v;
        logic [3:0]  alu1;
        logic [3:0]  alu0;
        logic        mul_v;
        logic [3:0]  mul_i;
        logic        mem_v;
        logic [3:0]  mem_i;
        logic [15:0] gvec;
        logic        mul_busy;
        logic        mem_busy;
    } res_t;

    logic clock;
    logic reset;
    int   n_assert;
    int   n_fail;
    res_t obs;
    res_t exp_r;
    res_t exp_q[$];

    fu_issue_arbiter_if #(.RS_SIZE(16), .NUM_ALU(2)) bus ();

    fu_issue_arbiter #(.RS_SIZE(16), .NUM_ALU(2), .MUL_LAT(4)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    assign obs = '{alu_v: bus.alu_grant_valid, alu1: bus.alu_grant_idx[7:4],
                   alu0: bus.alu_grant_idx[3:0], mul_v: bus.mul_grant_valid,
                   mul_i: bus.mul_grant_idx, mem_v: bus.mem_grant_valid,
                   mem_i: bus.mem_grant_idx, gvec: bus.grant_vec,
                   mul_busy: bus.mul_busy, mem_busy: bus.mem_busy};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic res_t mk(logic [1:0] av, int a0, int a1, logic mv, int mi,
                                logic ev, int ei, logic mb, logic eb);
        res_t r;
        r.alu_v    = av;
        r.alu0     = 4'(a0);
        r.alu1     = 4'(a1);
        r.mul_v    = mv;
        r.mul_i    = 4'(mi);
        r.mem_v    = ev;
        r.mem_i    = 4'(ei);
        r.mul_busy = mb;
        r.mem_busy = eb;
        r.gvec     = '0;
        if (av[0]) r.gvec[4'(a0)] = 1'b1;
        if (av[1]) r.gvec[4'(a1)] = 1'b1;
        if (mv)    r.gvec[4'(mi)] = 1'b1;
        if (ev)    r.gvec[4'(ei)] = 1'b1;
        return r;
    endfunction

    task automatic clear_in();
        bus.req_valid = '0;
        bus.req_fu    = '0;
        bus.squash    = 1'b0;
        bus.mem_done  = 1'b0;
    endtask

    task automatic put(int i, logic [1:0] fu);
        bus.req_valid[i]      = 1'b1;
        bus.req_fu[2*i +: 2]  = fu;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_in();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int c = 0; c < 2; c++) begin
            clear_in();
            put(3, F_ALU); put(5, F_MUL); put(7, F_MEM);
            exp_q.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
            #1;
            exp_r = exp_q.pop_front();
            n_assert++;
            if (obs !== exp_r) begin
                n_fail++;
                $display("FAIL reset_hold c%0d: got %h want %h", c, obs, exp_r);
            end
            @(negedge clock);
        end
    endtask

    task automatic test_alu_rr();
        do_reset();
        for (int c = 0; c < 5; c++) begin
            clear_in();
            if (c < 4) begin
                put(1, F_ALU); put(3, F_ALU); put(5, F_ALU);
            end else begin
                put(3, F_ALU);
            end
            case (c)
                0: exp_q.push_back(mk(2'b11, 1, 3, 0, 0, 0, 0, 0, 0));
                1: exp_q.push_back(mk(2'b11, 5, 1, 0, 0, 0, 0, 0, 0));
                2: exp_q.push_back(mk(2'b11, 3, 5, 0, 0, 0, 0, 0, 0));
                3: exp_q.push_back(mk(2'b11, 1, 3, 0, 0, 0, 0, 0, 0));
                default: exp_q.push_back(mk(2'b01, 3, 0, 0, 0, 0, 0, 0, 0));
            endcase
            #1;
            exp_r = exp_q.pop_front();
            n_assert++;
            if (obs !== exp_r) begin
                n_fail++;
                $display("FAIL alu_rr c%0d: got %h want %h", c, obs, exp_r);
            end
            @(negedge clock);
        end
    endtask

    task automatic test_mul_occupancy();
        do_reset();
        for (int c = 0; c < 9; c++) begin
            logic mv;
            clear_in();
            put(2, F_MUL); put(6, F_MUL); put(9, F_ALU);
            mv = (c % 4 == 0);
            exp_q.push_back(mk(2'b01, 9, 0, mv, (c == 4) ? 6 : (mv ? 2 : 0),
                               0, 0, !mv, 0));
            #1;
            exp_r = exp_q.pop_front();
            n_assert++;
            if (obs !== exp_r) begin
                n_fail++;
                $display("FAIL mul_occ c%0d: got %h want %h", c, obs, exp_r);
            end
            @(negedge clock);
        end
    endtask

    task automatic test_mem_bypass();
        do_reset();
        for (int c = 0; c < 8; c++) begin
            clear_in();
            case (c)
                0: begin put(4, F_MEM); exp_q.push_back(mk(2'b00, 0, 0, 0, 0, 1, 4, 0, 0)); end
                1, 2: begin put(7, F_MEM); exp_q.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 1)); end
                3: begin
                    put(7, F_MEM); bus.mem_done = 1'b1;
                    exp_q.push_back(mk(2'b00, 0, 0, 0, 0, 1, 7, 0, 1));
                end
                4: exp_q.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 1));
                5: begin bus.mem_done = 1'b1; exp_q.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 1)); end
                6: begin
                    put(2, F_MEM); bus.mem_done = 1'b1;
                    exp_q.push_back(mk(2'b00, 0, 0, 0, 0, 1, 2, 0, 0));
                end
                default: exp_q.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 1));
            endcase
            #1;
            exp_r = exp_q.pop_front();
            n_assert++;
            if (obs !== exp_r) begin
                n_fail++;
                $display("FAIL mem_bypass c%0d: got %h want %h", c, obs, exp_r);
            end
            @(negedge clock);
        end
    endtask

    task automatic test_squash();
        do_reset();
        for (int c = 0; c < 4; c++) begin
            clear_in();
            put(1, F_ALU); put(12, F_ALU); put(14, F_ALU);
            put(3, F_MUL); put(8, F_MUL);
            put(5, F_MEM); put(10, F_MEM);
            case (c)
                0: exp_q.push_back(mk(2'b11, 1, 12, 1, 3, 1, 5, 0, 0));
                1: begin
                    bus.squash = 1'b1; bus.mem_done = 1'b1;
                    exp_q.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 1, 1));
                end
                2: exp_q.push_back(mk(2'b11, 1, 12, 1, 3, 1, 5, 0, 0));
                default: exp_q.push_back(mk(2'b11, 14, 1, 0, 0, 0, 0, 1, 1));
            endcase
            #1;
            exp_r = exp_q.pop_front();
            n_assert++;
            if (obs !== exp_r) begin
                n_fail++;
                $display("FAIL squash c%0d: got %h want %h", c, obs, exp_r);
            end
            @(negedge clock);
        end
    endtask

    task automatic test_alu_wrap();
        do_reset();
        for (int c = 0; c < 4; c++) begin
            clear_in();
            case (c)
                0: begin put(14, F_ALU); exp_q.push_back(mk(2'b01, 14, 0, 0, 0, 0, 0, 0, 0)); end
                1: begin
                    put(15, F_ALU); put(0, F_ALU); put(1, F_MUL); put(8, F_BAD);
                    exp_q.push_back(mk(2'b11, 15, 0, 1, 1, 0, 0, 0, 0));
                end
                2: begin
                    put(15, F_ALU); put(0, F_ALU); put(1, F_MUL); put(8, F_BAD);
                    exp_q.push_back(mk(2'b11, 15, 0, 0, 0, 0, 0, 1, 0));
                end
                default: begin put(8, F_BAD); exp_q.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 1, 0)); end
            endcase
            #1;
            exp_r = exp_q.pop_front();
            n_assert++;
            if (obs !== exp_r) begin
                n_fail++;
                $display("FAIL alu_wrap c%0d: got %h want %h", c, obs, exp_r);
            end
            @(negedge clock);
        end
    endtask

    task automatic test_reset_midrun();
        do_reset();
        for (int c = 0; c < 6; c++) begin
            clear_in();
            case (c)
                0: begin
                    put(2, F_MUL); put(6, F_MEM);
                    exp_q.push_back(mk(2'b00, 0, 0, 1, 2, 1, 6, 0, 0));
                end
                1, 2: exp_q.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 1, 1));
                3, 4: begin
                    reset = 1'b1;
                    put(3, F_ALU); put(2, F_MUL); put(6, F_MEM);
                    exp_q.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
                end
                default: begin
                    reset = 1'b0;
                    exp_q.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
                end
            endcase
            #1;
            exp_r = exp_q.pop_front();
            n_assert++;
            if (obs !== exp_r) begin
                n_fail++;
                $display("FAIL reset_midrun c%0d: got %h want %h", c, obs, exp_r);
            end
            // Assert reset mid-cycle right after the busy check, before the next edge.
            if (c == 2) begin
                clear_in();
                reset = 1'b1;
                put(3, F_ALU); put(2, F_MUL); put(6, F_MEM);
                exp_q.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
                #1;
                exp_r = exp_q.pop_front();
                n_assert++;
                if (obs !== exp_r) begin
                    n_fail++;
                    $display("FAIL reset_async: got %h want %h", obs, exp_r);
                end
            end
            @(negedge clock);
        end
        reset = 1'b0;
        clear_in();
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        reset    = 1'b1;
        clear_in();
        test_reset();
        test_alu_rr();
        test_mul_occupancy();
        test_mem_bypass();
        test_squash();
        test_alu_wrap();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
